// File: rtl/etcpu_mem_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Holds the FSM state encoding, owner tags and the default widths.
package etcpu_mem_pkg;

    localparam int MEM_AW_DEF     = 32;
    localparam int MEM_DW_DEF     = 32;
    localparam int MEM_STARVE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } mem_owner_e;

    // Width of a counter that must be able to hold the value max.
    function automatic int starve_cw(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Priority pick between fetch and data requesters with a fetch starvation guard.
// Data wins by default; fetch is forced through once it has waited STARVE_MAX data wins.
module mem_arb_prio
    import etcpu_mem_pkg::*;
#(
    parameter int  STARVE_MAX = MEM_STARVE_DEF,
    localparam int CW         = starve_cw(STARVE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_arb,
    input  logic          i_if_req,
    input  logic          i_dm_req,
    output mem_owner_e    o_pick,
    output logic [CW-1:0] o_starve
);

    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve;
    logic          w_fetch_due;

    assign w_fetch_due = (r_starve == MAXV);
    assign o_starve    = r_starve;

    always_comb begin
        o_pick = OWN_IF;
        if (i_dm_req && !(i_if_req && w_fetch_due)) begin
            o_pick = OWN_DM;
        end
    end

    // Only data wins that leave a fetch waiting count toward starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (i_arb) begin
            if (o_pick == OWN_IF || !i_if_req) begin
                r_starve <= '0;
            end else if (!w_fetch_due) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port between an instruction fetch requester and a data requester.
// One transaction is in flight at a time: arbitrate in IDLE, issue in REQ, collect read data in RESP.
module mem_arb
    import etcpu_mem_pkg::*;
#(
    parameter int  AW         = MEM_AW_DEF,
    parameter int  DW         = MEM_DW_DEF,
    parameter int  STARVE_MAX = MEM_STARVE_DEF,
    localparam int CW         = starve_cw(STARVE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvld,
    output logic [DW-1:0] if_rdat,
    input  logic          dm_req,
    input  logic [AW-1:0] dm_addr,
    input  logic          dm_wen,
    input  logic [DW-1:0] dm_wdat,
    output logic          dm_gnt,
    output logic          dm_rvld,
    output logic [DW-1:0] dm_rdat,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdat,
    input  logic          mem_gnt,
    input  logic          mem_rvld,
    input  logic [DW-1:0] mem_rdat,
    output mem_state_e    o_dbg_state,
    output logic [CW-1:0] o_dbg_starve
);

    // Handshake: a requester raises req with stable addr/data and holds it until its gnt;
    // gnt is the single cycle in which mem_req and mem_gnt are both high. Read data
    // arrives later as a one-cycle rvld on the owner only, and only while in RESP.

    mem_state_e    r_state;
    mem_state_e    w_next;
    mem_owner_e    r_owner;
    logic [AW-1:0] r_addr;
    logic          r_wen;
    logic [DW-1:0] r_wdat;

    mem_owner_e    w_pick;
    logic          w_arb;

    assign w_arb       = (r_state == IDLE) && (if_req || dm_req);
    assign o_dbg_state = r_state;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_arb    (w_arb),
        .i_if_req (if_req),
        .i_dm_req (dm_req),
        .o_pick   (w_pick),
        .o_starve (o_dbg_starve)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_arb) w_next = REQ;
            REQ: begin
                if (mem_gnt) begin
                    w_next = r_wen ? IDLE : RESP;
                end
            end
            RESP: if (mem_rvld) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = r_addr;
        mem_wdat = r_wdat;
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        if_rvld  = 1'b0;
        dm_rvld  = 1'b0;
        if_rdat  = '0;
        dm_rdat  = '0;
        case (r_state)
            REQ: begin
                mem_req = 1'b1;
                mem_wen = r_wen;
                if (mem_gnt) begin
                    if_gnt = (r_owner == OWN_IF);
                    dm_gnt = (r_owner == OWN_DM);
                end
            end
            RESP: begin
                if (mem_rvld) begin
                    if (r_owner == OWN_IF) begin
                        if_rvld = 1'b1;
                        if_rdat = mem_rdat;
                    end else begin
                        dm_rvld = 1'b1;
                        dm_rdat = mem_rdat;
                    end
                end
            end
            default: ;
        endcase
    end

    // Fetch transactions are always reads, so their write data is parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdat  <= '0;
        end else if (w_arb) begin
            r_owner <= w_pick;
            if (w_pick == OWN_DM) begin
                r_addr <= dm_addr;
                r_wen  <= dm_wen;
                r_wdat <= dm_wdat;
            end else begin
                r_addr <= if_addr;
                r_wen  <= 1'b0;
                r_wdat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: per-cycle vector table plus hand sequences
// for starvation and reset in the middle of a read.
module tb_mem_arb;
  import etcpu_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvld;
  logic [31:0] if_rdat;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_wen;
  logic [31:0] dm_wdat;
  logic        dm_gnt;
  logic        dm_rvld;
  logic [31:0] dm_rdat;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdat;
  logic        mem_gnt;
  logic        mem_rvld;
  logic [31:0] mem_rdat;
  mem_state_e  dbg_state;
  logic [2:0]  dbg_starve;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arb #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvld      (if_rvld),
    .if_rdat      (if_rdat),
    .dm_req       (dm_req),
    .dm_addr      (dm_addr),
    .dm_wen       (dm_wen),
    .dm_wdat      (dm_wdat),
    .dm_gnt       (dm_gnt),
    .dm_rvld      (dm_rvld),
    .dm_rdat      (dm_rdat),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdat     (mem_wdat),
    .mem_gnt      (mem_gnt),
    .mem_rvld     (mem_rvld),
    .mem_rdat     (mem_rdat),
    .o_dbg_state  (dbg_state),
    .o_dbg_starve (dbg_starve)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        dw;
    logic [31:0] dd;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_mwen;
    logic [31:0] e_mwdat;
    logic        e_ignt;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_dgnt;
    logic        e_drv;
    logic [31:0] e_drd;
    mem_state_e  e_st;
  } vec_t;

  vec_t vecs[$];
  logic [0:0] exp_q[$];

  function automatic vec_t mk(string nm, logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                              logic dw, logic [31:0] dd, logic g, logic rv, logic [31:0] rd,
                              logic emr, logic [31:0] ema, logic emw, logic [31:0] emd,
                              logic eig, logic eiv, logic [31:0] eid,
                              logic edg, logic edv, logic [31:0] edd, mem_state_e est);
    vec_t v;
    v.name = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.dd = dd;
    v.g = g; v.rv = rv; v.rd = rd;
    v.e_mreq = emr; v.e_maddr = ema; v.e_mwen = emw; v.e_mwdat = emd;
    v.e_ignt = eig; v.e_irv = eiv; v.e_ird = eid;
    v.e_dgnt = edg; v.e_drv = edv; v.e_drd = edd; v.e_st = est;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic dw, input logic [31:0] dd, input logic g, input logic rv,
                       input logic [31:0] rd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_addr = da; dm_wen = dw; dm_wdat = dd;
    mem_gnt = g; mem_rvld = rv; mem_rdat = rd;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".mem_req"},  32'(mem_req),   32'(v.e_mreq));
    chk({tag, ".mem_addr"}, mem_addr,       v.e_maddr);
    chk({tag, ".mem_wen"},  32'(mem_wen),   32'(v.e_mwen));
    chk({tag, ".mem_wdat"}, mem_wdat,       v.e_mwdat);
    chk({tag, ".if_gnt"},   32'(if_gnt),    32'(v.e_ignt));
    chk({tag, ".if_rvld"},  32'(if_rvld),   32'(v.e_irv));
    chk({tag, ".if_rdat"},  if_rdat,        v.e_ird);
    chk({tag, ".dm_gnt"},   32'(dm_gnt),    32'(v.e_dgnt));
    chk({tag, ".dm_rvld"},  32'(dm_rvld),   32'(v.e_drv));
    chk({tag, ".dm_rdat"},  dm_rdat,        v.e_drd);
    chk({tag, ".state"},    32'(dbg_state), 32'(v.e_st));
  endtask

  vec_t zero_v;
  int   grants;
  int   dm_k;
  logic saw_if;

  initial begin
    zero_v = mk("zero", 0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0, IDLE);

    // cycle-by-cycle vectors; each row is one clock, checked before its rising edge
    vecs.push_back(mk("fetch_arb",  1,32'h100, 0,0,0,0, 0,0,0,             0,32'h0,0,0,    0,0,0,            0,0,0,            IDLE));
    vecs.push_back(mk("fetch_gnt",  1,32'h100, 0,0,0,0, 1,0,0,             1,32'h100,0,0,  1,0,0,            0,0,0,            REQ));
    vecs.push_back(mk("fetch_rvld", 0,0, 0,0,0,0,       0,1,32'hDEADBEEF,  0,32'h100,0,0,  0,1,32'hDEADBEEF, 0,0,0,            RESP));
    vecs.push_back(mk("stray_idle", 0,0, 0,0,0,0,       0,1,32'h55,        0,32'h100,0,0,  0,0,0,            0,0,0,            IDLE));
    vecs.push_back(mk("both_arb",   1,32'h200, 1,32'h8000,0,0, 0,0,0,      0,32'h100,0,0,  0,0,0,            0,0,0,            IDLE));
    vecs.push_back(mk("dm_accept",  1,32'h200, 1,32'h8000,0,0, 1,1,32'hBAD, 1,32'h8000,0,0, 0,0,0,           1,0,0,            REQ));
    vecs.push_back(mk("dm_rvld",    1,32'h200, 0,0,0,0, 0,1,32'h11112222,  0,32'h8000,0,0, 0,0,0,            0,1,32'h11112222, RESP));
    vecs.push_back(mk("if_arb",     1,32'h200, 0,0,0,0, 0,0,0,             0,32'h8000,0,0, 0,0,0,            0,0,0,            IDLE));
    vecs.push_back(mk("if_gnt",     1,32'h200, 0,0,0,0, 1,0,0,             1,32'h200,0,0,  1,0,0,            0,0,0,            REQ));
    vecs.push_back(mk("if_rvld",    0,0, 0,0,0,0,       0,1,32'h33334444,  0,32'h200,0,0,  0,1,32'h33334444, 0,0,0,            RESP));
    vecs.push_back(mk("quiet",      0,0, 0,0,0,0,       0,0,0,             0,32'h200,0,0,  0,0,0,            0,0,0,            IDLE));
    vecs.push_back(mk("wr_arb",     0,0, 1,32'h40,1,32'h12345678, 0,0,0,   0,32'h200,0,0,  0,0,0,            0,0,0,            IDLE));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("wr_wait",  0,0, 1,32'h40,1,32'h12345678, 0,0,0,   1,32'h40,1,32'h12345678, 0,0,0,   0,0,0,            REQ));
    vecs.push_back(mk("wr_gnt",     0,0, 1,32'h40,1,32'h12345678, 1,0,0,   1,32'h40,1,32'h12345678, 0,0,0,   1,0,0,            REQ));
    vecs.push_back(mk("wr_done",    0,0, 0,0,0,0,       0,1,32'h77,        0,32'h40,0,32'h12345678, 0,0,0,   0,0,0,            IDLE));
    vecs.push_back(mk("quiet2",     0,0, 0,0,0,0,       0,0,0,             0,32'h40,0,32'h12345678, 0,0,0,   0,0,0,            IDLE));

    // reset: outputs stay zero even with a request pending
    rst_n = 1'b0;
    drive(1, 32'h999, 1, 32'h888, 1, 32'h777, 1, 1, 32'h666);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk_all("reset", mk("r", 0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0, IDLE));
    chk("reset.starve", 32'(dbg_starve), 32'd0);
    @(negedge clk);

    // release reset and start the table on the same negedge
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].da, vecs[i].dw, vecs[i].dd,
            vecs[i].g, vecs[i].rv, vecs[i].rd);
      #2;
      chk_all(vecs[i].name, vecs[i]);
      @(negedge clk);
    end

    // starvation: both requesters hold reads, memory answers at once
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    grants = 0;
    dm_k   = 0;
    saw_if = 1'b0;
    drive(1, 32'h300, 1, 32'h9000, 0, 0, 1, 1, 32'h0);
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      #2;
      chk("starve.gnt_excl", 32'(if_gnt & dm_gnt), 32'd0);
      if (if_gnt || dm_gnt) begin
        if (exp_q.size() == 0) begin
          chk("starve.extra_gnt", 32'(grants), 32'd5);
        end else begin
          chk("starve.order", 32'(dm_gnt), 32'(exp_q.pop_front()));
        end
        if (dm_gnt) begin
          dm_k++;
          chk("starve.cnt_dm", 32'(dbg_starve), 32'(dm_k));
          chk("starve.addr_dm", mem_addr, 32'h9000);
        end else begin
          saw_if = 1'b1;
          chk("starve.cnt_clr", 32'(dbg_starve), 32'd0);
          chk("starve.addr_if", mem_addr, 32'h300);
        end
        grants++;
      end
      @(negedge clk);
      if (saw_if) if_req = 1'b0;
    end
    chk("starve.grants", 32'(grants), 32'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    #2;
    chk("starve.if_rvld", 32'(if_rvld), 32'd1);
    chk("starve.if_rdat", if_rdat, 32'hCAFE);
    chk("starve.dm_rvld", 32'(dm_rvld), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("starve.idle", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);

    // reset while a data read waits in RESP
    drive(0, 0, 1, 32'h500, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'h500, 0, 0, 1, 0, 0);
    #2;
    chk("rst_mid.dm_gnt", 32'(dm_gnt), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_mid.in_resp", 32'(dbg_state), 32'(RESP));
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid.async", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF);
    #2;
    chk_all("rst_mid.stray", zero_v);
    @(negedge clk);
    drive(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_mid.arb_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    drive(1, 32'h600, 0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("rst_mid.if_gnt", 32'(if_gnt), 32'd1);
    chk("rst_mid.addr", mem_addr, 32'h600);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5);
    #2;
    chk("rst_mid.if_rvld", 32'(if_rvld), 32'd1);
    chk("rst_mid.if_rdat", if_rdat, 32'hA5A5A5A5);
    chk("rst_mid.dm_rvld", 32'(dm_rvld), 32'd0);
    @(negedge clk);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while fetch waits.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports if_req in 1, if_addr in AW, if_gnt out 1, if_rvld out 1, if_rdat out DW: fetch requester, read-only.
REQ-007 SHALL have ports dm_req in 1, dm_addr in AW, dm_wen in 1, dm_wdat in DW, dm_gnt out 1, dm_rvld out 1, dm_rdat out DW: data requester.
REQ-008 SHALL have ports mem_req out 1, mem_addr out AW, mem_wen out 1, mem_wdat out DW, mem_gnt in 1, mem_rvld in 1, mem_rdat in DW: single shared memory port.

Function
REQ-009 SHALL share one memory port between fetch and data, with at most one transaction outstanding.
REQ-010 SHALL implement FSM states IDLE, REQ, RESP.
REQ-011 IDLE: when any req is high, SHALL latch winner, addr, wen, wdat into registers and go to REQ next cycle; otherwise stay.
REQ-012 Arbitration SHALL give data priority, except fetch wins when starve count equals STARVE_MAX.
REQ-013 Starve count SHALL increment (saturating at STARVE_MAX) on each data win while if_req is high, and clear on a fetch win or on any arbitration with if_req low.
REQ-014 REQ: mem_req, mem_addr, mem_wen, mem_wdat SHALL be driven from registers only; mem_req=1 holds until mem_gnt.
REQ-015 On mem_req and mem_gnt, owner gnt SHALL pulse high that same cycle (combinational, one cycle); non-owner gnt stays 0.
REQ-016 After acceptance: read SHALL go to RESP; write SHALL go to IDLE with no rvld.
REQ-017 RESP: on mem_rvld, owner rvld SHALL pulse that cycle with rdat = mem_rdat; FSM returns to IDLE next cycle.
REQ-018 if_rdat/dm_rdat SHALL be 0 whenever own rvld is 0.
REQ-019 mem_rvld outside RESP, including the acceptance cycle, SHALL be ignored.
REQ-020 if_gnt SHALL never be asserted together with dm_gnt; likewise rvld.
REQ-021 Requesters hold req/addr/data stable until gnt; a req dropped before arbitration is simply not served.
REQ-022 Minimum read latency: req in cycle 0, mem_req cycle 1, rvld cycle 2 when memory responds immediately.
REQ-023 Outside REQ, mem_req, mem_wen SHALL be 0; mem_addr, mem_wdat hold registered values.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, starve count 0, all registers 0, all outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it; a later stray mem_rvld SHALL be ignored per REQ-019.
REQ-026 First arbitration SHALL occur on the first rising edge with rst_n high.

Structure
REQ-027 Shared package etcpu_mem_pkg SHALL hold the FSM state enum, owner enum (OWN_IF, OWN_DM) and default width constants.
REQ-028 Starvation counter and priority pick SHALL live in sub-module mem_arb_prio; FSM and datapath registers stay in mem_arb.

Verification
REQ-029 Fetch read alone: if_req=1, if_addr=0x100, mem_gnt=1, mem_rvld=1 with mem_rdat=0xDEADBEEF in next cycle -> if_gnt cycle 1, if_rvld with if_rdat=0xDEADBEEF cycle 2.
REQ-030 Simultaneous req: if_addr=0x200, dm_addr=0x8000 read -> mem_addr=0x8000 first, then 0x200; dm_rdat, if_rdat routed correctly.
REQ-031 Starvation: dm_req held with continuous reads, if_req high, STARVE_MAX=4 -> 4 data grants then one fetch grant, count cleared.
REQ-032 Write: dm_wen=1, dm_addr=0x40, dm_wdat=0x12345678, mem_gnt delayed 3 cycles -> mem_req held 3 cycles with stable values, dm_gnt one pulse, no dm_rvld, IDLE next.
REQ-033 Reset in RESP: rst_n low during pending read, then mem_rvld=1 after release -> no rvld, all outputs 0, next request served normally.
REQ-034 Stray mem_rvld in IDLE and in acceptance cycle -> no if_rvld/dm_rvld.
